muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the execute stage, the multi-cycle partner to the single-cycle ALU. It executes MULT, MULTU, DIV and DIVU over 34 cycles and owns the architectural HI/LO registers. It also handles MTHI/MTLO writes. The pipeline issues into it with a valid/busy handshake and stalls on `busy`; MFHI/MFLO read `hi`/`lo` directly.

## Interface
- No parameters; data width fixed at 32.
- `clk` input 1: sole clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `valid_in` input 1: request present this cycle.
- `op` input 3: operation code (package constants).
- `a` input 32: rs operand (multiplicand / dividend / MTHI-MTLO data).
- `b` input 32: rt operand (multiplier / divisor).
- `cancel` input 1: abort the in-flight operation (exception flush).
- `busy` output 1: operation in progress; request not accepted.
- `done` output 1: one-cycle pulse; `hi`/`lo` hold the new result.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- **Reset (async, `resetn`=0):** state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- **States:**
  - IDLE → CALC on accept of MULT/MULTU/DIV/DIVU.
  - CALC → FIX after 32 iterations.
  - FIX → IDLE.
- **Accept:** `valid_in` && !`busy` at a rising edge. `valid_in` is ignored while `busy`; the issuer must hold the request.
- **On accept:**
  - Latch absolute operand values for signed ops, raw values for unsigned ops.
  - Latch result signs: product/quotient negative iff `a[31]`^`b[31]`; remainder sign = `a[31]`. Latch a div-by-zero flag.
- **Multiply (CALC):**
  - 64-bit accumulator, radix-2 shift-add.
  - One multiplier bit per cycle, LSB first, 32 cycles.
- **Divide (CALC):**
  - Restoring, one quotient bit per cycle, MSB first, 32 cycles.
  - 33-bit trial subtract of the divisor from the partial remainder.
- **FIX:** negate the 64-bit product, or the quotient/remainder independently, per the latched signs.
- **FIX→IDLE edge:** write `hi` = product[63:32] / remainder and `lo` = product[31:0] / quotient; `done`=1 for exactly one cycle.
- **Divide by zero (either signedness):** `lo`=32'hFFFF_FFFF, `hi`=`a` as issued; sign fix is skipped.
- **Signed overflow:** 0x8000_0000 / 0xFFFF_FFFF yields `lo`=0x8000_0000, `hi`=0. This is the natural result of the magnitude path; no special case.
- **MTHI/MTLO:**
  - Accepted only in IDLE.
  - Write `a` to `hi`/`lo` at the accept edge, visible the next cycle.
  - No `busy`, no `done`.
- **Undefined op codes:** accepted as no-ops; no state change.
- **`cancel`:**
  - In CALC or FIX: return to IDLE at the next edge. `hi`/`lo` are unchanged and no `done` is produced.
  - In IDLE: suppresses any accept in that same cycle.
  - If `cancel` and an accepting `valid_in` coincide, `cancel` wins.
- **Reset mid-operation:** immediate abandonment; all outputs take their reset values.

## Timing
- Accept edge at cycle N:
  - `busy`=1 during cycles N+1 … N+33 (32 CALC + 1 FIX).
  - `done`=1 and new `hi`/`lo` visible in cycle N+34.
  - `busy`=0 in N+34, so the next request can be accepted at the end of N+34.
- Back-to-back ops therefore complete every 34 cycles.
- `hi`/`lo` are stable throughout CALC/FIX; readers never see partial results.
- `done` and `busy` are never high together.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- **Shared package** (`common.svh` / cpu package):
  - Op constants: MD_MULT=3'b000, MD_MULTU=3'b001, MD_DIV=3'b010, MD_DIVU=3'b011, MD_MTHI=3'b100, MD_MTLO=3'b101.
  - State enum `md_state_t` {IDLE, CALC, FIX}.
  - Iteration count constant MD_ITER=32.
- **Sub-module `muldiv_step`:** combinational single-iteration datapath.
  - Inputs: accumulator, operand, mode.
  - Output: next accumulator (shift-add or trial-subtract).
- **Top:** FSM, 5-bit counter, sign/flag latches, FIX negation, HI/LO registers.

## Test plan
- MULTU a=0xFFFF_FFFF b=0xFFFF_FFFF → `done` at N+34; `hi`=0xFFFF_FFFE, `lo`=0x0000_0001; `busy` high N+1..N+33.
- MULT a=0xFFFF_FFFD (−3) b=5 → `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFF1.
- DIV a=0xFFFF_FFF9 (−7) b=2 → `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF. DIVU 7/2 → `lo`=3, `hi`=1.
- DIV 0x8000_0000 / 0xFFFF_FFFF → `lo`=0x8000_0000, `hi`=0. DIVU 5/0 → `lo`=0xFFFF_FFFF, `hi`=5.
- DIV issued; `cancel` at N+10 → `busy`=0 at N+11, no `done`, `hi`/`lo` unchanged. Then MTHI a=0x1234 → `hi`=0x1234 next cycle, no `done`.
- MULT in flight; `resetn` low at N+20 → `busy`, `done`, `hi`, `lo` all 0 immediately. A `valid_in` held during `busy` is ignored and accepted only once `busy` drops.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the iterative multiply/divide unit: operation codes
// presented on the op port, FSM state encoding, datapath step mode and the
// iteration count of the shift-add / restoring-divide loop.
// ---------------------------------------------------------------------------
package muldiv_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } md_mode_t;

endpackage

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// Combinational single-iteration datapath of the multiply/divide unit.
//   acc      : 64-bit working accumulator
//              multiply : {partial product high, remaining multiplier bits}
//              divide   : {partial remainder, dividend bits / quotient bits}
//   operand  : multiplicand (multiply) or divisor (divide), magnitude form
//   mode     : MODE_MUL -> radix-2 shift-add, LSB of multiplier first
//              MODE_DIV -> restoring trial subtract, quotient MSB first
//   acc_next : accumulator after one iteration
// ---------------------------------------------------------------------------
module muldiv_step
  import muldiv_unit_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  input  md_mode_t    mode,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] partial;
  logic [32:0] trial;

  always_comb begin
    // Shift-add: the 33-bit sum keeps the carry, which becomes the new MSB
    // once the accumulator shifts right by one.
    sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    // Restoring divide: remainder shifted left with the next dividend bit.
    // The remainder stays below the divisor, so 33 bits never overflow and
    // trial[32] is a reliable borrow.
    partial = acc[63:31];
    trial   = partial - {1'b0, operand};

    if (mode == MODE_MUL) begin
      acc_next = {sum, acc[31:1]};
    end else if (trial[32]) begin
      acc_next = {partial[31:0], acc[30:0], 1'b0};
    end else begin
      acc_next = {trial[31:0], acc[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO
// registers; also performs MTHI/MTLO writes. An operation takes 34 cycles
// (32 iterations + 1 sign-fix cycle); the issuer holds its request while
// busy is high.
//   clk      : clock, rising edge
//   resetn   : asynchronous active-low reset
//   valid_in : request present (ignored while busy)
//   op       : operation code (MD_* in muldiv_unit_pkg)
//   a, b     : rs / rt operands
//   cancel   : abort the operation in flight, or suppress an accept in IDLE
//   busy     : operation in progress
//   done     : one-cycle pulse, hi/lo hold the new result
//   hi, lo   : HI / LO registers
// ---------------------------------------------------------------------------
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_in,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] LAST_ITER = 5'(MD_ITER - 1);

  md_state_t   state, state_nxt;
  logic [4:0]  cnt;
  logic        load, iter, commit, wr_hi, wr_lo;

  logic        op_signed, op_div, b_zero;
  logic [31:0] a_mag, b_mag;

  logic [63:0] acc, acc_step;
  logic [31:0] opnd;
  md_mode_t    mode;
  logic        neg_q, neg_r, dbz;
  logic [63:0] res;

  logic        done_q;
  logic [31:0] hi_q, lo_q;

  // Magnitude of a two's-complement operand; 0x8000_0000 maps onto itself,
  // which read as unsigned is the correct magnitude.
  function automatic logic [31:0] mag32(input logic signed [31:0] v,
                                        input logic is_signed);
    logic signed [31:0] n;
    n = -v;
    return (is_signed && (v < 0)) ? n : v;
  endfunction

  function automatic logic [31:0] cond_neg32(input logic signed [31:0] v,
                                             input logic neg);
    logic signed [31:0] n;
    n = -v;
    return neg ? n : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic signed [63:0] v,
                                             input logic neg);
    logic signed [63:0] n;
    n = -v;
    return neg ? n : v;
  endfunction

  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign op_div    = (op == MD_DIV)  || (op == MD_DIVU);
  assign b_zero    = (b == 32'd0);
  assign a_mag     = mag32(a, op_signed);
  assign b_mag     = mag32(b, op_signed);

  // FSM: next state and control strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    iter      = 1'b0;
    commit    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid_in && !cancel) begin
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              load      = 1'b1;
              state_nxt = CALC;
            end
            MD_MTHI: wr_hi = 1'b1;
            MD_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else begin
          iter = 1'b1;
          if (cnt == LAST_ITER) state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = IDLE;
        commit    = !cancel;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      done_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      state  <= state_nxt;
      done_q <= commit;
      if (load)      cnt <= 5'd0;
      else if (iter) cnt <= cnt + 5'd1;
      if (commit)     hi_q <= res[63:32];
      else if (wr_hi) hi_q <= a;
      if (commit)     lo_q <= res[31:0];
      else if (wr_lo) lo_q <= a;
    end
  end

  // Accept: latch magnitudes, signs and the divide-by-zero flag
  always_ff @(posedge clk) begin
    if (load) begin
      mode  <= op_div ? MODE_DIV : MODE_MUL;
      neg_q <= op_signed && (a[31] ^ b[31]);
      neg_r <= op_signed && a[31];
      dbz   <= op_div && b_zero;
      if (op_div) begin
        // With a zero divisor every trial subtract succeeds, so the loop
        // yields quotient all-ones and leaves the raw dividend as remainder.
        acc  <= {32'd0, b_zero ? a : a_mag};
        opnd <= b_mag;
      end else begin
        acc  <= {32'd0, b_mag};
        opnd <= a_mag;
      end
    end else if (iter) begin
      acc <= acc_step;
    end
  end

  // CALC: one iteration per cycle
  muldiv_step u_step (
    .acc      (acc),
    .operand  (opnd),
    .mode     (mode),
    .acc_next (acc_step)
  );

  // FIX: sign correction of the magnitude result
  always_comb begin
    if (mode == MODE_MUL) begin
      res = cond_neg64(acc, neg_q);
    end else if (dbz) begin
      res = acc;
    end else begin
      res = {cond_neg32(acc[63:32], neg_r), cond_neg32(acc[31:0], neg_q)};
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid_in = 1'b0;
  logic        cancel = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv_unit dut (
    .clk      (clk),
    .resetn   (resetn),
    .valid_in (valid_in),
    .op       (op),
    .a        (a),
    .b        (b),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          bs = 1;
  int          be = 0;
  int          last_n = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural values.
  function automatic logic [63:0] ref_md(input logic [2:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      MD_MULT:  return 64'(sx * sy);
      MD_MULTU: return ux * uy;
      MD_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: busy window, HI/LO stability and scoreboard on done.
  always @(negedge clk) begin
    if (resetn) begin
      chk("busy", 64'(busy), 64'(cyc >= bs && cyc <= be));
      chk("busy_done_excl", 64'(busy & done), 64'd0);
      if (done) begin
        if (sbq.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_cycle", 64'(mon_e.cyc), 64'(cyc));
          chk("hi_result", 64'(hi), 64'(mon_e.hi));
          chk("lo_result", 64'(lo), 64'(mon_e.lo));
          m_hi = mon_e.hi;
          m_lo = mon_e.lo;
        end
      end else begin
        chk("hi_hold", 64'(hi), 64'(m_hi));
        chk("lo_hold", 64'(lo), 64'(m_lo));
      end
    end
  end

  // Present a request and hold it until it is accepted.
  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    int guard;
    exp_t e;
    logic [63:0] r;
    guard = 0;
    @(negedge clk);
    valid_in = 1'b1;
    op = o;
    a = x;
    b = y;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      chk("accept_timeout", 64'd1, 64'd0);
      valid_in = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_n = cyc - 1;
    case (o)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
        r = ref_md(o, x, y);
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.cyc = last_n + 34;
        sbq.push_back(e);
        bs = last_n + 1;
        be = last_n + 33;
      end
      MD_MTHI: m_hi = x;
      MD_MTLO: m_lo = x;
      default: ;
    endcase
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sbq.size() > 0 || busy) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (sbq.size() > 0) begin
      chk("drain_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cycle(input int target);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (cyc < target && g < 200);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int          n;

    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Directed: second request held while the first is busy.
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(MD_MULT,  32'hFFFF_FFFD, 32'd5);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd2);
    issue(MD_DIVU,  32'd7,         32'd2);
    issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    issue(MD_DIVU,  32'd5,         32'd0);
    issue(MD_DIV,   32'hFFFF_FFF0, 32'd0);
    issue(MD_DIV,   32'd7,         32'hFFFF_FFFE);
    drain();

    // Cancel mid-divide, then MTHI / MTLO / undefined op.
    issue(MD_DIV, 32'd100, 32'd7);
    n = last_n;
    wait_cycle(n + 10);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    be = n + 10;
    void'(sbq.pop_back());
    issue(MD_MTHI, 32'h0000_1234, 32'd0);
    issue(MD_MTLO, 32'hCAFE_0001, 32'd0);
    issue(3'b110,  32'hDEAD_BEEF, 32'd1);
    issue(3'b111,  32'hDEAD_BEEF, 32'd1);

    // Cancel coinciding with an accept in IDLE: nothing happens.
    @(negedge clk);
    valid_in = 1'b1;
    op = MD_MTHI;
    a = 32'h5555_5555;
    cancel = 1'b1;
    @(negedge clk);
    op = MD_MULTU;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    cancel = 1'b0;
    repeat (40) @(negedge clk);

    // Randomized operations.
    for (int i = 0; i < 14; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      case ($urandom_range(0, 5))
        0:       ry = 32'd0;
        1:       ry = 32'($urandom_range(1, 15));
        2:       ry = 32'hFFFF_FFFF;
        default: ry = $urandom;
      endcase
      if (i % 5 == 4) issue(MD_MTHI, $urandom, 32'd0);
      issue(ro, rx, ry);
    end
    drain();

    // Asynchronous reset in the middle of a multiply.
    issue(MD_MULT, 32'h1234_5678, 32'h8765_4321);
    n = last_n;
    wait_cycle(n + 20);
    resetn = 1'b0;
    sbq.delete();
    bs = 1;
    be = 0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    issue(MD_MULTU, 32'd3, 32'd4);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
